// File: rtl/ysyx_25040129_mem_rd_arbiter_pkg.sv
// Shared definitions for the IFU/LSU read-channel arbiter: FSM state
// encoding, AXI response and size codes.
package ysyx_25040129_mem_rd_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IFU_AR = 3'd1,
        ST_IFU_R  = 3'd2,
        ST_LSU_AR = 3'd3,
        ST_LSU_R  = 3'd4
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    // Any response other than OKAY (SLVERR, DECERR, EXOKAY) is reported as a bus error
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_25040129_mem_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4-lite read arbiter.
// LSU has fixed priority; a streak counter forces an IFU grant after
// MAX_LSU_STREAK consecutive LSU grants taken while the IFU was waiting.
// The grant is registered in IDLE and held from AR handshake to R handshake.
module ysyx_25040129_mem_rd_arbiter
    import ysyx_25040129_mem_rd_arbiter_pkg::*;
#(
    parameter int MAX_LSU_STREAK = 4,
    parameter int STREAK_W       = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ifu_araddr,
    input  logic [2:0]  ifu_arsize,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,

    output logic [31:0] s_araddr,
    output logic [2:0]  s_arsize,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,

    output logic        bus_err
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    arb_state_e          state;
    logic [STREAK_W-1:0] streak;
    logic                ifu_starved;
    logic                lsu_wins;

    // IFU overrides LSU priority only once the LSU has used up its streak
    assign ifu_starved = ifu_arvalid && (streak == STREAK_MAX);
    assign lsu_wins    = lsu_arvalid && !ifu_starved;

    // Read data and response are broadcast; only the owner ever sees rvalid
    assign ifu_rdata = s_rdata;
    assign ifu_rresp = s_rresp;
    assign lsu_rdata = s_rdata;
    assign lsu_rresp = s_rresp;

    // Grant decision, transaction progress, streak bookkeeping and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            streak  <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (lsu_wins) begin
                        state <= ST_LSU_AR;
                        if (!ifu_arvalid) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + STREAK_ONE;
                        end
                    end else if (ifu_arvalid) begin
                        state  <= ST_IFU_AR;
                        streak <= '0;
                    end
                end
                ST_IFU_AR: begin
                    if (ifu_arvalid && s_arready) state <= ST_IFU_R;
                end
                ST_IFU_R: begin
                    if (s_rvalid && ifu_rready) begin
                        state   <= ST_IDLE;
                        bus_err <= resp_is_err(s_rresp);
                    end
                end
                ST_LSU_AR: begin
                    if (lsu_arvalid && s_arready) state <= ST_LSU_R;
                end
                ST_LSU_R: begin
                    if (s_rvalid && lsu_rready) begin
                        state   <= ST_IDLE;
                        bus_err <= resp_is_err(s_rresp);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Route the owner's AR/R handshake signals; everything idles low otherwise
    always_comb begin
        s_araddr    = '0;
        s_arsize    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        case (state)
            ST_IFU_AR: begin
                s_araddr    = ifu_araddr;
                s_arsize    = ifu_arsize;
                s_arvalid   = ifu_arvalid;
                ifu_arready = s_arready;
            end
            ST_IFU_R: begin
                ifu_rvalid = s_rvalid;
                s_rready   = ifu_rready;
            end
            ST_LSU_AR: begin
                s_araddr    = lsu_araddr;
                s_arsize    = lsu_arsize;
                s_arvalid   = lsu_arvalid;
                lsu_arready = s_arready;
            end
            ST_LSU_R: begin
                lsu_rvalid = s_rvalid;
                s_rready   = lsu_rready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_mem_rd_arbiter.sv
// Randomized scoreboard bench for the IFU/LSU read arbiter.
// Master and slave models drive the DUT; a separate monitor checks grant
// order, signal routing, returned data and the bus error pulse.
module tb_ysyx_25040129_mem_rd_arbiter;
    import ysyx_25040129_mem_rd_arbiter_pkg::*;

    localparam int MAX_STREAK = 4;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr, s_araddr;
    logic [2:0]  ifu_arsize, lsu_arsize, s_arsize;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] ifu_rdata, lsu_rdata, s_rdata;
    logic [1:0]  ifu_rresp, lsu_rresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        bus_err;

    ysyx_25040129_mem_rd_arbiter #(
        .MAX_LSU_STREAK(MAX_STREAK),
        .STREAK_W      (4)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arvalid(ifu_arvalid),
        .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
        .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Slave memory content and response as a pure function of the address
    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0413;
    endfunction
    function automatic logic [1:0] slv_resp(input logic [31:0] a);
        return (a[5:4] == 2'b11) ? 2'b10 : RESP_OKAY;
    endfunction

    // Scoreboard: {rresp, rdata} expected by each master
    logic [33:0] exp_ifu_q[$];
    logic [33:0] exp_lsu_q[$];

    // Stimulus state (index 0 = IFU, 1 = LSU)
    logic        m_en[2], m_arvalid[2], m_out[2], m_rready[2];
    logic [31:0] m_addr[2];
    logic [2:0]  m_size[2];
    logic [2:0]  sz_tab[3];
    int          gap_max, rready_pct, arready_pct, rlat_max;
    logic        rvalid_block;
    logic        sl_pend;
    int          sl_cnt;
    logic [31:0] sl_addr;

    // Handshakes observed by the monitor, consumed by the drivers next cycle
    logic        hs_ar[2], hs_r[2], hs_s_ar, hs_s_r;
    logic [31:0] hs_addr;

    // Reference arbitration model
    logic        busy, ar_done, pending, exp_lsu, cur_lsu, exp_err, prev_rst;
    int          lsu_run;

    task automatic apply();
        ifu_arvalid = m_arvalid[0]; ifu_araddr = m_addr[0]; ifu_arsize = m_size[0]; ifu_rready = m_rready[0];
        lsu_arvalid = m_arvalid[1]; lsu_araddr = m_addr[1]; lsu_arsize = m_size[1]; lsu_rready = m_rready[1];
    endtask

    task automatic drive_cycle();
        // slave
        if (hs_s_r) begin
            s_rvalid = 1'b0;
            sl_pend  = 1'b0;
        end
        if (hs_s_ar) begin
            sl_pend = 1'b1;
            sl_addr = hs_addr;
            sl_cnt  = $urandom_range(0, rlat_max);
        end
        if (sl_pend && !s_rvalid && !rvalid_block) begin
            if (sl_cnt == 0) begin
                s_rvalid = 1'b1;
                s_rdata  = slv_data(sl_addr);
                s_rresp  = slv_resp(sl_addr);
            end else begin
                sl_cnt--;
            end
        end
        if (!s_rvalid) begin
            s_rdata = $urandom;
            s_rresp = 2'($urandom_range(0, 3));
        end
        s_arready = ($urandom_range(0, 99) < arready_pct);
        // masters
        for (int m = 0; m < 2; m++) begin
            if (hs_ar[m]) m_arvalid[m] = 1'b0;
            if (hs_r[m])  m_out[m]     = 1'b0;
            if (!m_arvalid[m] && !m_out[m] && m_en[m] && ($urandom_range(0, gap_max) == 0)) begin
                m_addr[m]    = (m == 1 ? 32'h8000_0000 : 32'h3000_0000) | (32'($urandom_range(0, 16383)) << 2);
                m_size[m]    = sz_tab[$urandom_range(0, 2)];
                m_arvalid[m] = 1'b1;
                m_out[m]     = 1'b1;
                if (m == 1) exp_lsu_q.push_back({slv_resp(m_addr[m]), slv_data(m_addr[m])});
                else        exp_ifu_q.push_back({slv_resp(m_addr[m]), slv_data(m_addr[m])});
            end
            m_rready[m] = ($urandom_range(0, 99) < rready_pct);
        end
        apply();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_cycle();
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_arvalid[m] = 1'b0; m_out[m] = 1'b0; m_rready[m] = 1'b0; m_en[m] = 1'b0;
        end
        s_rvalid = 1'b0; s_arready = 1'b0; sl_pend = 1'b0;
        exp_ifu_q.delete();
        exp_lsu_q.delete();
        apply();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_knobs(input logic ie, input logic le, input int gap, input int rr, input int ar, input int rl);
        m_en[0] = ie; m_en[1] = le;
        gap_max = gap; rready_pct = rr; arready_pct = ar; rlat_max = rl;
    endtask

    task automatic drain(input string name);
        m_en[0] = 1'b0; m_en[1] = 1'b0;
        rvalid_block = 1'b0; rready_pct = 80; arready_pct = 80; rlat_max = 2;
        for (int i = 0; i < 300 && (m_out[0] || m_out[1] || busy || pending); i++) run_cycles(1);
        check(name, {m_out[0], m_out[1], busy, pending}, 4'b0);
        run_cycles(2);
        check({name, "_queues"}, 64'(exp_ifu_q.size() + exp_lsu_q.size()), 0);
    endtask

    // Monitor: reference arbitration and routing checks, sampled mid-cycle
    logic [31:0] own_addr;
    logic [2:0]  own_size;
    logic        own_arvalid, own_arready, own_rvalid, own_rready, oth_arready, oth_rvalid;
    logic [33:0] exp_r;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                busy = 0; ar_done = 0; pending = 0; lsu_run = 0; exp_err = 0; prev_rst = 1;
                hs_ar[0] = 0; hs_ar[1] = 0; hs_r[0] = 0; hs_r[1] = 0; hs_s_ar = 0; hs_s_r = 0;
            end else begin
                if (prev_rst)
                    check("post_reset_outputs",
                          {ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, s_arvalid, s_rready, bus_err, s_araddr, s_arsize}, 0);
                prev_rst = 0;
                check("bus_err", bus_err, exp_err);
                exp_err = s_rvalid && s_rready && (s_rresp != RESP_OKAY);
                hs_ar[0] = ifu_arvalid && ifu_arready;
                hs_ar[1] = lsu_arvalid && lsu_arready;
                hs_r[0]  = ifu_rvalid && ifu_rready;
                hs_r[1]  = lsu_rvalid && lsu_rready;
                hs_s_ar  = s_arvalid && s_arready;
                hs_s_r   = s_rvalid && s_rready;
                hs_addr  = s_araddr;
                if (!busy) begin
                    if (pending) begin
                        check("grant_latency", s_arvalid, 1);
                        check("grant_owner_is_lsu", s_araddr[31], exp_lsu);
                        busy = 1; ar_done = 0; pending = 0; cur_lsu = exp_lsu;
                    end else begin
                        check("idle_quiet", {s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid}, 0);
                        if (lsu_arvalid && !(ifu_arvalid && lsu_run == MAX_STREAK)) begin
                            pending = 1; exp_lsu = 1;
                            lsu_run = ifu_arvalid ? ((lsu_run < MAX_STREAK) ? lsu_run + 1 : MAX_STREAK) : 0;
                        end else if (ifu_arvalid) begin
                            pending = 1; exp_lsu = 0; lsu_run = 0;
                        end
                    end
                end
                if (busy) begin
                    own_addr    = cur_lsu ? lsu_araddr  : ifu_araddr;
                    own_size    = cur_lsu ? lsu_arsize  : ifu_arsize;
                    own_arvalid = cur_lsu ? lsu_arvalid : ifu_arvalid;
                    own_arready = cur_lsu ? lsu_arready : ifu_arready;
                    oth_arready = cur_lsu ? ifu_arready : lsu_arready;
                    own_rvalid  = cur_lsu ? lsu_rvalid  : ifu_rvalid;
                    oth_rvalid  = cur_lsu ? ifu_rvalid  : lsu_rvalid;
                    own_rready  = cur_lsu ? lsu_rready  : ifu_rready;
                    if (!ar_done) begin
                        check("ar_addr", s_araddr, own_addr);
                        check("ar_size", s_arsize, own_size);
                        check("ar_valid", s_arvalid, own_arvalid);
                        check("ar_ready_route", {own_arready, oth_arready, own_rvalid, oth_rvalid}, {s_arready, 3'b000});
                        if (s_arvalid && s_arready) ar_done = 1;
                    end else begin
                        check("r_route", {own_rvalid, oth_rvalid, s_rready, own_arready, oth_arready, s_arvalid},
                              {s_rvalid, 1'b0, own_rready, 3'b000});
                        if (own_rvalid && own_rready) begin
                            if (cur_lsu ? (exp_lsu_q.size() == 0) : (exp_ifu_q.size() == 0)) begin
                                check("r_unexpected", 1, 0);
                            end else begin
                                exp_r = cur_lsu ? exp_lsu_q.pop_front() : exp_ifu_q.pop_front();
                                check(cur_lsu ? "lsu_rdata_rresp" : "ifu_rdata_rresp",
                                      {(cur_lsu ? lsu_rresp : ifu_rresp), (cur_lsu ? lsu_rdata : ifu_rdata)}, exp_r);
                            end
                        end
                        if (s_rvalid && s_rready) busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        sz_tab[0] = SIZE_BYTE; sz_tab[1] = SIZE_HALF; sz_tab[2] = SIZE_WORD;
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = '0; m_size[m] = '0;
        end
        busy = 0; pending = 0; ar_done = 0; cur_lsu = 0; exp_lsu = 0;
        s_rdata = '0; s_rresp = '0; sl_cnt = 0; sl_addr = '0; rvalid_block = 1'b0;
        set_knobs(0, 0, 0, 100, 100, 0);
        do_reset(3);

        // mixed random traffic with varied slave latency and back-pressure
        set_knobs(1, 1, 3, 70, 60, 3);
        run_cycles(400);
        drain("drain_mixed");

        // both masters saturating, zero-latency slave: starvation guard order
        set_knobs(1, 1, 0, 100, 100, 0);
        run_cycles(120);
        drain("drain_starve");

        // slow slave: long AR stalls must hold address and grant
        set_knobs(1, 1, 2, 90, 15, 2);
        run_cycles(250);
        drain("drain_slow");

        // reset while LSU waits for its response
        rvalid_block = 1'b1;
        set_knobs(0, 1, 0, 100, 100, 0);
        rvalid_block = 1'b1;
        for (int i = 0; i < 40 && !(busy && ar_done && cur_lsu); i++) run_cycles(1);
        check("reach_lsu_r", {busy, ar_done, cur_lsu}, 3'b111);
        do_reset(1);
        rvalid_block = 1'b0;

        // streak restarts from zero after reset
        set_knobs(1, 1, 0, 100, 100, 0);
        run_cycles(80);
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
